// File: rtl/f2c_queue_manager.sv
// Per-queue packet/descriptor ring bookkeeping ahead of the FPGA-to-CPU DMA stage.
// One registered output stage; ring state lives in per-queue register arrays.
module f2c_queue_manager #(
  parameter int NB_QUEUES    = 16,
  parameter int QUEUE_AWIDTH = 4,
  parameter int RB_AWIDTH    = 16,
  parameter int SIZE_WIDTH   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [QUEUE_AWIDTH-1:0] in_queue_id,
  input  logic [SIZE_WIDTH-1:0]   in_size,
  input  logic [RB_AWIDTH:0]      pkt_rb_size,
  input  logic [RB_AWIDTH:0]      dsc_rb_size,
  input  logic                    cfg_wr_en,
  input  logic [QUEUE_AWIDTH-1:0] cfg_queue_id,
  input  logic [1:0]              cfg_sel,
  input  logic [63:0]             cfg_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [QUEUE_AWIDTH-1:0] out_queue_id,
  output logic [SIZE_WIDTH-1:0]   out_size,
  output logic [63:0]             out_pkt_kmem_addr,
  output logic [RB_AWIDTH-1:0]    out_pkt_tail,
  output logic [63:0]             out_dsc_kmem_addr,
  output logic [RB_AWIDTH-1:0]    out_dsc_tail,
  output logic                    out_drop,
  output logic                    out_needs_dsc,
  output logic [31:0]             drop_cnt
);

  typedef struct packed {
    logic [QUEUE_AWIDTH-1:0] queue_id;
    logic [SIZE_WIDTH-1:0]   size;
    logic [63:0]             pkt_kmem_addr;
    logic [RB_AWIDTH-1:0]    pkt_tail;
    logic [63:0]             dsc_kmem_addr;
    logic [RB_AWIDTH-1:0]    dsc_tail;
    logic                    drop;
    logic                    needs_dsc;
  } meta_t;

  logic [RB_AWIDTH-1:0] pkt_mask, dsc_mask;
  logic [RB_AWIDTH-1:0] pkt_tail [NB_QUEUES];
  logic [RB_AWIDTH-1:0] dsc_tail [NB_QUEUES];
  logic [RB_AWIDTH-1:0] pkt_head [NB_QUEUES];
  logic [RB_AWIDTH-1:0] dsc_head [NB_QUEUES];
  logic [63:0]          pkt_kmem [NB_QUEUES];
  logic [63:0]          dsc_kmem [NB_QUEUES];

  logic [RB_AWIDTH-1:0] cur_pkt_tail, cur_dsc_tail, pkt_free, dsc_free, size_ext;
  logic [RB_AWIDTH-1:0] pkt_tail_nxt, dsc_tail_nxt;
  logic [63:0]          cur_pkt_kmem, cur_dsc_kmem;
  logic                 accept, drop;
  logic [NB_QUEUES-1:0] cfg_hit, upd_hit;
  meta_t                meta_in, meta_q;

  // A full-range ring (top bit set) has every index bit in the mask.
  always_ff @(posedge clk) begin
    pkt_mask <= pkt_rb_size[RB_AWIDTH] ? '1 : pkt_rb_size[RB_AWIDTH-1:0] - RB_AWIDTH'(1);
    dsc_mask <= dsc_rb_size[RB_AWIDTH] ? '1 : dsc_rb_size[RB_AWIDTH-1:0] - RB_AWIDTH'(1);
  end

  assign in_ready = out_ready | ~out_valid;
  assign accept   = in_valid & in_ready;

  assign cur_pkt_tail = pkt_tail[in_queue_id];
  assign cur_dsc_tail = dsc_tail[in_queue_id];
  assign cur_pkt_kmem = pkt_kmem[in_queue_id];
  assign cur_dsc_kmem = dsc_kmem[in_queue_id];
  assign size_ext     = RB_AWIDTH'(in_size);

  // One slot stays empty so head == tail always means an empty ring.
  assign pkt_free = (pkt_head[in_queue_id] - cur_pkt_tail - RB_AWIDTH'(1)) & pkt_mask;
  assign dsc_free = (dsc_head[in_queue_id] - cur_dsc_tail - RB_AWIDTH'(1)) & dsc_mask;
  assign drop     = (cur_pkt_kmem == '0) | (cur_dsc_kmem == '0) |
                    (size_ext > pkt_free) | (dsc_free == '0);

  assign pkt_tail_nxt = (cur_pkt_tail + size_ext) & pkt_mask;
  assign dsc_tail_nxt = (cur_dsc_tail + RB_AWIDTH'(1)) & dsc_mask;

  always_comb begin
    cfg_hit = '0;
    upd_hit = '0;
    if (cfg_wr_en)        cfg_hit[cfg_queue_id] = 1'b1;
    if (accept && !drop)  upd_hit[in_queue_id]  = 1'b1;
  end

  // A kmem_addr write resets that ring and overrides a same-cycle tail advance.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_QUEUES; i++) begin
      if (rst) begin
        pkt_tail[i] <= '0;
        dsc_tail[i] <= '0;
        pkt_head[i] <= '0;
        dsc_head[i] <= '0;
        pkt_kmem[i] <= '0;
        dsc_kmem[i] <= '0;
      end else begin
        if (cfg_hit[i] && cfg_sel == 2'd0) begin
          pkt_kmem[i] <= cfg_data;
          pkt_tail[i] <= '0;
        end else if (upd_hit[i]) begin
          pkt_tail[i] <= pkt_tail_nxt;
        end
        if (cfg_hit[i] && cfg_sel == 2'd1) begin
          dsc_kmem[i] <= cfg_data;
          dsc_tail[i] <= '0;
        end else if (upd_hit[i]) begin
          dsc_tail[i] <= dsc_tail_nxt;
        end
        if (cfg_hit[i] && cfg_sel == 2'd2) pkt_head[i] <= cfg_data[RB_AWIDTH-1:0];
        if (cfg_hit[i] && cfg_sel == 2'd3) dsc_head[i] <= cfg_data[RB_AWIDTH-1:0];
      end
    end
  end

  always_comb begin
    meta_in               = '0;
    meta_in.queue_id      = in_queue_id;
    meta_in.size          = in_size;
    meta_in.pkt_kmem_addr = cur_pkt_kmem;
    meta_in.pkt_tail      = cur_pkt_tail;
    meta_in.dsc_kmem_addr = cur_dsc_kmem;
    meta_in.dsc_tail      = cur_dsc_tail;
    meta_in.drop          = drop;
    meta_in.needs_dsc     = ~drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      meta_q    <= '0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (accept)   meta_q    <= meta_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sw_reset)
      drop_cnt <= '0;
    else if (accept && drop && drop_cnt != '1)
      drop_cnt <= drop_cnt + 32'd1;
  end

  assign out_queue_id      = meta_q.queue_id;
  assign out_size          = meta_q.size;
  assign out_pkt_kmem_addr = meta_q.pkt_kmem_addr;
  assign out_pkt_tail      = meta_q.pkt_tail;
  assign out_dsc_kmem_addr = meta_q.dsc_kmem_addr;
  assign out_dsc_tail      = meta_q.dsc_tail;
  assign out_drop          = meta_q.drop;
  assign out_needs_dsc     = meta_q.needs_dsc;

endmodule

// File: tb/tb_f2c_queue_manager.sv
// Bench for f2c_queue_manager: directed scenarios plus random traffic against a
// modulo-arithmetic ring model with an expected-output queue.
module tb_f2c_queue_manager;

  logic        clk = 1'b0;
  logic        rst, sw_reset, in_valid, in_ready, cfg_wr_en, out_valid, out_ready;
  logic [3:0]  in_queue_id, cfg_queue_id, out_queue_id;
  logic [5:0]  in_size, out_size;
  logic [16:0] pkt_rb_size, dsc_rb_size;
  logic [1:0]  cfg_sel;
  logic [63:0] cfg_data, out_pkt_kmem_addr, out_dsc_kmem_addr;
  logic [15:0] out_pkt_tail, out_dsc_tail;
  logic        out_drop, out_needs_dsc;
  logic [31:0] drop_cnt;

  f2c_queue_manager dut (
    .clk(clk), .rst(rst), .sw_reset(sw_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_queue_id(in_queue_id), .in_size(in_size),
    .pkt_rb_size(pkt_rb_size), .dsc_rb_size(dsc_rb_size),
    .cfg_wr_en(cfg_wr_en), .cfg_queue_id(cfg_queue_id), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_queue_id(out_queue_id), .out_size(out_size),
    .out_pkt_kmem_addr(out_pkt_kmem_addr), .out_pkt_tail(out_pkt_tail),
    .out_dsc_kmem_addr(out_dsc_kmem_addr), .out_dsc_tail(out_dsc_tail),
    .out_drop(out_drop), .out_needs_dsc(out_needs_dsc), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: ring positions as plain integers, wrapped with modulo.
  typedef logic [171:0] rec_t;
  rec_t        exp_q[$];
  int          m_ptail[16], m_dtail[16], m_phead[16], m_dhead[16];
  logic [63:0] m_pk[16], m_dk[16];
  longint      m_drops;
  int          m_psz = 64, m_dsz = 16;

  function automatic int wrap(int v, int sz);
    return ((v % sz) + sz) % sz;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_drops = 0;
    for (int i = 0; i < 16; i++) begin
      m_ptail[i] = 0; m_dtail[i] = 0; m_phead[i] = 0; m_dhead[i] = 0;
      m_pk[i] = '0;   m_dk[i] = '0;
    end
  endfunction

  function automatic void model_accept(int q, int sz);
    int  pf, df;
    logic drp;
    pf  = wrap(m_phead[q] - m_ptail[q] - 1, m_psz);
    df  = wrap(m_dhead[q] - m_dtail[q] - 1, m_dsz);
    drp = (m_pk[q] == 0) || (m_dk[q] == 0) || (sz > pf) || (df == 0);
    exp_q.push_back({4'(q), 6'(sz), m_pk[q], 16'(m_ptail[q]), m_dk[q], 16'(m_dtail[q]), drp, !drp});
    if (drp) begin
      if (m_drops < 64'hFFFF_FFFF) m_drops++;
    end else begin
      m_ptail[q] = wrap(m_ptail[q] + sz, m_psz);
      m_dtail[q] = wrap(m_dtail[q] + 1, m_dsz);
    end
  endfunction

  function automatic void model_cfg(int q, int sel, logic [63:0] d);
    case (sel)
      0: begin m_pk[q] = d; m_ptail[q] = 0; end
      1: begin m_dk[q] = d; m_dtail[q] = 0; end
      2: m_phead[q] = int'(d[15:0]);
      default: m_dhead[q] = int'(d[15:0]);
    endcase
  endfunction

  function automatic logic [172:0] model_out();
    return (exp_q.size() != 0) ? {1'b1, exp_q[0]} : 173'd0;
  endfunction

  function automatic logic [172:0] dut_out();
    return out_valid ? {1'b1, out_queue_id, out_size, out_pkt_kmem_addr, out_pkt_tail,
                        out_dsc_kmem_addr, out_dsc_tail, out_drop, out_needs_dsc} : 173'd0;
  endfunction

  // One clock of stimulus; returns #1 after the edge with the model advanced.
  task automatic drive(input logic v, input int q, input int sz, input logic ordy,
                       input logic cw, input int cq, input int cs, input logic [63:0] cd,
                       input logic sw);
    logic rdy;
    in_valid = v; in_queue_id = 4'(q); in_size = 6'(sz); out_ready = ordy;
    cfg_wr_en = cw; cfg_queue_id = 4'(cq); cfg_sel = 2'(cs); cfg_data = cd; sw_reset = sw;
    rdy = ordy || (exp_q.size() == 0);
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (v && rdy) model_accept(q, sz);
    if (cw) model_cfg(cq, cs, cd);
    if (sw) m_drops = 0;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_wr_en = 1'b0; sw_reset = 1'b0;
  endtask

  task automatic send(input int q, input int sz);
    drive(1'b1, q, sz, 1'b1, 1'b0, 0, 0, 64'd0, 1'b0);
  endtask

  task automatic cfg(input int q, input int sel, input logic [63:0] d);
    drive(1'b0, 0, 1, 1'b1, 1'b1, q, sel, d, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; cfg_wr_en = 1'b0; sw_reset = 1'b0; out_ready = 1'b1;
    in_queue_id = '0; in_size = 6'd1; cfg_queue_id = '0; cfg_sel = '0; cfg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({out_valid, dut_out(), drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got v=%b out=%h drop_cnt=%0d, want all zero", out_valid, dut_out(), drop_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int exp_t[2][2] = '{'{0, 0}, '{5, 1}};
    int sz[2] = '{5, 2};
    cfg(3, 0, 64'h1000);
    cfg(3, 1, 64'h2000);
    for (int i = 0; i < 2; i++) begin
      send(3, sz[i]);
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL basic out[%0d]: got %h want %h", i, dut_out(), model_out()); end
      checks++;
      if ({out_pkt_tail, out_dsc_tail, out_drop, out_needs_dsc} !== {16'(exp_t[i][0]), 16'(exp_t[i][1]), 2'b01}) begin
        errors++;
        $display("FAIL basic tails[%0d]: got pkt=%0d dsc=%0d drop=%b nd=%b want pkt=%0d dsc=%0d drop=0 nd=1",
                 i, out_pkt_tail, out_dsc_tail, out_drop, out_needs_dsc, exp_t[i][0], exp_t[i][1]);
      end
    end
  endtask

  task automatic test_wrap();
    int sz[4] = '{31, 31, 1, 1};
    cfg(5, 0, 64'h3000);
    cfg(5, 1, 64'h4000);
    for (int i = 0; i < 4; i++) begin
      send(5, sz[i]);
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL wrap out[%0d]: got %h want %h", i, dut_out(), model_out()); end
    end
    checks++;
    if ({out_drop, out_pkt_tail, drop_cnt} !== {1'b1, 16'd63, 32'd1}) begin
      errors++;
      $display("FAIL wrap full-drop: got drop=%b tail=%0d cnt=%0d want drop=1 tail=63 cnt=1", out_drop, out_pkt_tail, drop_cnt);
    end
    cfg(5, 2, 64'd10);
    send(5, 4);
    checks++;
    if (dut_out() !== model_out() || out_pkt_tail !== 16'd63 || out_drop !== 1'b0) begin
      errors++; $display("FAIL wrap after head: got %h want %h (tail 63)", dut_out(), model_out());
    end
    send(5, 1);
    checks++;
    if (dut_out() !== model_out() || out_pkt_tail !== 16'd3) begin
      errors++; $display("FAIL wrap new tail: got %h want %h (tail 3)", dut_out(), model_out());
    end
  endtask

  task automatic test_no_dsc();
    cfg(7, 0, 64'h5000);
    for (int i = 0; i < 2; i++) begin
      send(7, 3);
      checks++;
      if (dut_out() !== model_out() || {out_drop, out_needs_dsc, out_pkt_tail, out_dsc_tail} !== {2'b10, 32'd0}) begin
        errors++; $display("FAIL no_dsc[%0d]: got %h want %h", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3, i + 1, 1'b0, 1'b0, 0, 0, 64'd0, 1'b0);
      checks++;
      if (dut_out() !== model_out() || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got %h rdy=%b want %h rdy=0", i, dut_out(), in_ready, model_out());
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, 3, 2, 1'b1, 1'b0, 0, 0, 64'd0, 1'b0);
      checks++;
      if (dut_out() !== model_out() || in_ready !== 1'b1) begin
        errors++; $display("FAIL release[%0d]: got %h rdy=%b want %h rdy=1", i, dut_out(), in_ready, model_out());
      end
    end
  endtask

  task automatic test_cfg_collision();
    cfg(2, 0, 64'h6000);
    cfg(2, 1, 64'h7000);
    send(2, 3);
    drive(1'b1, 2, 4, 1'b1, 1'b1, 2, 0, 64'h6100, 1'b0);
    checks++;
    if (dut_out() !== model_out() || out_pkt_kmem_addr !== 64'h6000 || out_pkt_tail !== 16'd3) begin
      errors++; $display("FAIL collide old: got %h want %h", dut_out(), model_out());
    end
    send(2, 1);
    checks++;
    if (dut_out() !== model_out() || {out_pkt_kmem_addr, out_pkt_tail, out_dsc_tail} !== {64'h6100, 16'd0, 16'd2}) begin
      errors++; $display("FAIL collide new: got %h want %h", dut_out(), model_out());
    end
    drive(1'b1, 2, 1, 1'b1, 1'b1, 2, 3, 64'd9, 1'b0);
    send(2, 1);
    checks++;
    if (dut_out() !== model_out()) begin errors++; $display("FAIL collide head: got %h want %h", dut_out(), model_out()); end
  endtask

  task automatic test_sw_reset();
    for (int i = 0; i < 7; i++) send(7, 1);
    checks++;
    if (drop_cnt !== 32'(m_drops)) begin errors++; $display("FAIL drops before clear: got %0d want %0d", drop_cnt, m_drops); end
    drive(1'b0, 0, 1, 1'b1, 1'b0, 0, 0, 64'd0, 1'b1);
    checks++;
    if (drop_cnt !== 32'd0) begin errors++; $display("FAIL sw_reset cnt: got %0d want 0", drop_cnt); end
    send(3, 1);
    checks++;
    if (dut_out() !== model_out()) begin errors++; $display("FAIL sw_reset tails: got %h want %h", dut_out(), model_out()); end
  endtask

  task automatic test_random();
    logic [63:0] d;
    for (int i = 0; i < 16; i++) begin
      cfg(i, 0, 64'h10000 + 64'(i));
      cfg(i, 1, 64'h20000 + 64'(i));
    end
    for (int n = 0; n < 800; n++) begin
      d = ($urandom_range(7) == 0) ? 64'd0 : {$urandom, $urandom};
      drive($urandom_range(9) < 7, $urandom_range(15), $urandom_range(63, 1), $urandom_range(3) != 0,
            $urandom_range(9) == 0, $urandom_range(15), $urandom_range(3), d, $urandom_range(99) == 0);
      checks++;
      if (dut_out() !== model_out() || drop_cnt !== 32'(m_drops) ||
          in_ready !== (out_ready || exp_q.size() == 0)) begin
        errors++;
        $display("FAIL random[%0d]: got %h cnt=%0d rdy=%b want %h cnt=%0d", n, dut_out(), drop_cnt, in_ready, model_out(), m_drops);
      end
    end
  endtask

  initial begin
    pkt_rb_size = 17'(m_psz);
    dsc_rb_size = 17'(m_dsz);
    test_reset();
    test_basic();
    test_wrap();
    test_no_dsc();
    test_backpressure();
    test_cfg_collision();
    test_sw_reset();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/f2c_queue_manager.md
Name: f2c_queue_manager

Overview:
- Sits directly upstream of the FPGA-to-CPU DMA stage and produces that stage's per-packet metadata.
- Takes per-packet metadata (queue id, size in 64B flits) and looks up per-queue packet-ring and descriptor-ring state.
- Checks CPU ring free space, assigns start tails, then advances the tails.
- Emits metadata carrying queue state, drop and needs_dsc flags; CPU head pointers and ring base addresses arrive through a config write port.

Parameters:
NB_QUEUES, 16, number of queues; queue state is held in register arrays.
QUEUE_AWIDTH, 4, queue id width, equal to log2(NB_QUEUES).
RB_AWIDTH, 16, ring index width in flits/descriptors.
SIZE_WIDTH, 6, packet size width in flits.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
sw_reset  in  1  synchronous counter clear
in_valid  in  1  input metadata valid
in_ready  out  1  input accepted when in_valid&in_ready
in_queue_id  in  QUEUE_AWIDTH  destination queue
in_size  in  SIZE_WIDTH  packet size in flits, 1..2^SIZE_WIDTH-1
pkt_rb_size  in  RB_AWIDTH+1  packet ring size, power of 2
dsc_rb_size  in  RB_AWIDTH+1  descriptor ring size, power of 2
cfg_wr_en  in  1  config write strobe
cfg_queue_id  in  QUEUE_AWIDTH  config target queue
cfg_sel  in  2  0=pkt kmem_addr, 1=dsc kmem_addr, 2=pkt head, 3=dsc head
cfg_data  in  64  config value; heads use [RB_AWIDTH-1:0]
out_valid  out  1  output metadata valid
out_ready  in  1  downstream accept
out_queue_id  out  QUEUE_AWIDTH  queue id
out_size  out  SIZE_WIDTH  size in flits
out_pkt_kmem_addr  out  64  packet ring base
out_pkt_tail  out  RB_AWIDTH  packet ring start tail
out_dsc_kmem_addr  out  64  descriptor ring base
out_dsc_tail  out  RB_AWIDTH  descriptor slot index
out_drop  out  1  packet must not be written
out_needs_dsc  out  1  descriptor must be written
drop_cnt  out  32  dropped-packet count

Behaviour:
- Reset (rst): all tails, heads and kmem_addrs = 0; out_valid=0; drop_cnt=0; all other outputs 0.
- sw_reset: clears drop_cnt only.
- Masks: pkt_mask = pkt_rb_size-1 and dsc_mask = dsc_rb_size-1, registered one cycle after the sizes.
- Handshake:
  - in_ready = out_ready | !out_valid, combinational.
  - Output register holds all fields stable while out_valid & !out_ready.
  - Latency is exactly 1 cycle: input accepted at edge t gives out_valid high after edge t.
- Lookup is combinational from the arrays using in_queue_id; the arrays and the output register update on the same edge.
- Free-space arithmetic, one slot kept empty, computed in RB_AWIDTH bits:
  - pkt_free = (pkt_head - pkt_tail - 1) & pkt_mask
  - dsc_free = (dsc_head - dsc_tail - 1) & dsc_mask
- drop = (pkt_kmem_addr==0) | (dsc_kmem_addr==0) | (in_size > pkt_free) | (dsc_free == 0).
- If not dropped:
  - pkt_tail <= (pkt_tail + in_size) & pkt_mask
  - dsc_tail <= (dsc_tail + 1) & dsc_mask
  - out_needs_dsc = 1
- If dropped: tails unchanged; out_needs_dsc = 0; out_drop = 1; drop_cnt += 1, saturating at 2^32-1. The packet is still emitted so downstream consumes its flits.
- Output tails carry the pre-increment values.
- Back-to-back packets to the same queue: the second packet must see the updated tail with no bubble.
- Config writes:
  - Writing a kmem_addr (sel 0/1) also sets the matching tail to 0.
  - Writing a head (sel 2/3) updates the head only.
- Same cycle, same queue, config and accepted packet:
  - A lookup uses the pre-write head and kmem_addr values.
  - A kmem_addr write wins over the packet's tail update for that ring; the other ring's tail update still applies.
  - A head write and a tail update both take effect.
- No state machine beyond the valid/hold register. Reset mid-stream discards the in-flight output with no partial update.

Test Plan:
- Queue 3 configured (pkt/dsc kmem_addr nonzero), pkt_rb_size=64, heads 0, in_size=5 -> out_pkt_tail=0, out_dsc_tail=0, drop=0, needs_dsc=1; next packet to q3 of size 2 on the next cycle -> out_pkt_tail=5, out_dsc_tail=1.
- Packet tail=62, head=0, size 1 -> accepted, tail wraps to 63; next size 1 -> pkt_free=0, drop=1, drop_cnt=1, tail stays 63; write pkt head=10 -> next size 4 gets out_pkt_tail=63, new tail=3.
- Queue with dsc kmem_addr=0 -> drop=1, needs_dsc=0, tails unchanged.
- Hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> one transfer per cycle, no loss or duplication.
- cfg pkt kmem_addr write to q2 in the same cycle as an accepted q2 packet -> packet emitted with the old addr/tail, q2 pkt tail=0 afterwards, dsc tail still advanced.
- sw_reset after 7 drops -> drop_cnt=0 while queue tails are preserved.
